window_comparator: RTL

Multi-channel, registered window comparator with persistence filtering. It is the sequential, parametrised successor to the plain magnitude comparator. Each valid sample vector is classified per channel against a shared low/high threshold pair. A per-channel alarm is raised only after PERSIST consecutive out-of-window samples and cleared only after PERSIST consecutive in-window samples. The block sits between sensor/ADC sample streams and the status/interrupt logic.

---
 rtl/window_comparator_if.sv | 28 ++
 rtl/window_comparator.sv | 127 ++++++++++++
 2 files changed

// File: rtl/window_comparator_if.sv
// Sample/threshold/status bundle for window_comparator.
// The master drives samples and thresholds; the slave (the comparator) drives status.
interface window_comparator_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic                      in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [WIDTH-1:0]          lo_thr;
    logic [WIDTH-1:0]          hi_thr;
    logic                      clear;
    logic                      out_valid;
    logic [CHANNELS-1:0]       zone_below;
    logic [CHANNELS-1:0]       zone_above;
    logic [CHANNELS-1:0]       alarm;
    logic                      alarm_any;
    logic                      cfg_err;

    modport master (
        output in_valid, in_data, lo_thr, hi_thr, clear,
        input  out_valid, zone_below, zone_above, alarm, alarm_any, cfg_err
    );

    modport slave (
        input  in_valid, in_data, lo_thr, hi_thr, clear,
        output out_valid, zone_below, zone_above, alarm, alarm_any, cfg_err
    );
endinterface

// File: rtl/window_comparator.sv
// Multi-channel registered window comparator with per-channel persistence filtering.
// Alarms toggle only after PERSIST consecutive valid samples disagreeing with the current state.
module window_comparator #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PERSIST  = 3,
    parameter int SIGNED   = 0
) (
    input logic           clk,
    input logic           rst_n,
    window_comparator_if.slave bus
);
    localparam int CW = $clog2(PERSIST + 1);
    localparam logic [CW-1:0] LAST = CW'(PERSIST - 1);

    typedef enum logic {NORMAL, ALARM} state_t;

    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic [CW-1:0]       cnt_q   [CHANNELS];
    logic [CW-1:0]       cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] below_d;
    logic [CHANNELS-1:0] above_d;
    logic [CHANNELS-1:0] outside;
    logic [CHANNELS-1:0] alarm_d;
    logic [CHANNELS-1:0] zone_below_q;
    logic [CHANNELS-1:0] zone_above_q;
    logic [CHANNELS-1:0] alarm_q;
    logic                out_valid_q;
    logic                alarm_any_q;
    logic                cfg_err_q;

    function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    always_comb begin
        below_d = '0;
        above_d = '0;
        outside = '0;
        alarm_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            below_d[i] = less(bus.in_data[i*WIDTH +: WIDTH], bus.lo_thr);
            above_d[i] = !below_d[i] && less(bus.hi_thr, bus.in_data[i*WIDTH +: WIDTH]);
            outside[i] = below_d[i] | above_d[i];
            if (bus.clear) begin
                state_d[i] = NORMAL;
                cnt_d[i]   = '0;
            end else if (bus.in_valid) begin
                // The counter tracks a run of samples contradicting the current state.
                unique case (state_q[i])
                    NORMAL: begin
                        if (!outside[i])
                            cnt_d[i] = '0;
                        else if (cnt_q[i] == LAST) begin
                            state_d[i] = ALARM;
                            cnt_d[i]   = '0;
                        end else
                            cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                    ALARM: begin
                        if (outside[i])
                            cnt_d[i] = '0;
                        else if (cnt_q[i] == LAST) begin
                            state_d[i] = NORMAL;
                            cnt_d[i]   = '0;
                        end else
                            cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                    default: begin
                        state_d[i] = NORMAL;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            alarm_d[i] = (state_d[i] == ALARM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= NORMAL;
                cnt_q[i]   <= '0;
            end
            zone_below_q <= '0;
            zone_above_q <= '0;
            out_valid_q  <= 1'b0;
            alarm_any_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            cfg_err_q   <= less(bus.hi_thr, bus.lo_thr);
            alarm_any_q <= |alarm_d;
            if (bus.clear) begin
                zone_below_q <= '0;
                zone_above_q <= '0;
                out_valid_q  <= 1'b0;
            end else begin
                out_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    zone_below_q <= below_d;
                    zone_above_q <= above_d;
                end
            end
        end
    end

    always_comb begin
        alarm_q = '0;
        for (int unsigned i = 0; i < CHANNELS; i++)
            alarm_q[i] = (state_q[i] == ALARM);
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.zone_below = zone_below_q;
    assign bus.zone_above = zone_above_q;
    assign bus.alarm      = alarm_q;
    assign bus.alarm_any  = alarm_any_q;
    assign bus.cfg_err    = cfg_err_q;
endmodule
